// File: rtl/xyc_pkg.sv
// ============================================================================
// Module  : xyc_pkg
// Brief   : Shared state encodings and sizing helper for xy_controller_array.
// Revision: 1.0
// ============================================================================
`default_nettype none

package xyc_pkg;

    // The encoding is the function code presented on {F1,F0}.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        FAULT = 2'b11
    } xyc_state_t;

    function automatic int hold_cnt_width(input int hold_cycles);
        return $clog2(hold_cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/xy_controller_array_if.sv
// ============================================================================
// Module  : xy_controller_array_if
// Brief   : Per-channel X/Y request bundle and function-code/status outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface xy_controller_array_if #(
    parameter int CHANNELS = 4
) ();
    logic [CHANNELS-1:0] X;
    logic [CHANNELS-1:0] Y;
    logic [CHANNELS-1:0] F1;
    logic [CHANNELS-1:0] F0;
    logic [CHANNELS-1:0] changed;
    logic                fault_any;

    modport master (
        output X, Y,
        input  F1, F0, changed, fault_any
    );

    modport slave (
        input  X, Y,
        output F1, F0, changed, fault_any
    );
endinterface

`default_nettype wire

// File: rtl/xyc_channel.sv
// ============================================================================
// Module  : xyc_channel
// Brief   : One X/Y Moore controller with return-to-idle hold filter and
//           change strobe. XYC_STICKY_FAULT_EN makes FAULT absorbing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xyc_channel
    import xyc_pkg::*;
#(
    parameter int HOLD_CYCLES = 3
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic x,
    input  wire logic y,
    output logic      f1,
    output logic      f0,
    output logic      changed,
    output logic      fault
);
    localparam int            CW        = hold_cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    xyc_state_t    state;
    xyc_state_t    state_next;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_next;
    logic          quiet;
    logic          hold_done;

    always_comb begin
        quiet      = !x && !y;
        // The exit fires on the edge where the count would reach HOLD_CYCLES.
        hold_done  = quiet && (hold_cnt == HOLD_LAST);
        state_next = state;
        hold_next  = '0;
        if (x && y) begin
            state_next = FAULT;
        end else begin
            case (state)
                IDLE:  if (x) state_next = RUN;
                RUN:   if (y) state_next = PAUSE;
                PAUSE: begin
                    if (x)              state_next = RUN;
                    else if (hold_done) state_next = IDLE;
                    else if (quiet)     hold_next  = hold_cnt + 1'b1;
                end
                FAULT: begin
`ifdef XYC_STICKY_FAULT_EN
                    state_next = FAULT;
`else
                    if (hold_done)  state_next = IDLE;
                    else if (quiet) hold_next  = hold_cnt + 1'b1;
`endif
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            changed  <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            changed  <= (state_next != state);
        end
    end

    assign f1    = state[1];
    assign f0    = state[0];
    assign fault = (state == FAULT);

endmodule

`default_nettype wire

// File: rtl/xy_controller_array.sv
// ============================================================================
// Module  : xy_controller_array
// Brief   : CHANNELS independent X/Y controllers with aggregated fault flag.
//           Optional macro: XYC_STICKY_FAULT_EN (FAULT left only by reset).
// Revision: 1.0
// ============================================================================
`default_nettype none

module xy_controller_array
    import xyc_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  wire logic              clock,
    input  wire logic              reset,
    xy_controller_array_if.slave   bus
);
    logic [CHANNELS-1:0] fault_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        xyc_channel #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .x       (bus.X[i]),
            .y       (bus.Y[i]),
            .f1      (bus.F1[i]),
            .f0      (bus.F0[i]),
            .changed (bus.changed[i]),
            .fault   (fault_vec[i])
        );
    end

    assign bus.fault_any = |fault_vec;

endmodule

`default_nettype wire

// File: tb/tb_xy_controller_array.sv
// ============================================================================
// Module  : tb_xy_controller_array
// Brief   : Directed plus randomized bench against a behavioural channel model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_xy_controller_array;
    localparam int CH   = 4;
    localparam int HOLD = 3;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    xy_controller_array_if #(.CHANNELS(CH)) bus ();

    xy_controller_array #(
        .CHANNELS    (CH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Model: per-channel function code, count of quiet edges spent waiting
    // to return to idle, and whether the code moved on the last edge.
    logic [1:0] exp_f   [CH];
    int         exp_run [CH];
    logic       exp_chg [CH];
    logic       model_valid = 1'b0;

    function automatic bit is_sticky();
`ifdef XYC_STICKY_FAULT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] next_f(input logic [1:0] f, input logic x, input logic y,
                                          input int run);
        if (x && y) return 2'd3;
        case (f)
            2'd0: return x ? 2'd1 : 2'd0;
            2'd1: return y ? 2'd2 : 2'd1;
            2'd2: begin
                if (x) return 2'd1;
                if (!y && run + 1 >= HOLD) return 2'd0;
                return 2'd2;
            end
            default: begin
                if (is_sticky()) return 2'd3;
                if (!x && !y && run + 1 >= HOLD) return 2'd0;
                return 2'd3;
            end
        endcase
    endfunction

    function automatic int next_run(input logic [1:0] f, input logic x, input logic y,
                                    input int run);
        if (x || y) return 0;
        if (f == 2'd0 || f == 2'd1) return 0;
        if (f == 2'd3 && is_sticky()) return 0;
        if (run + 1 >= HOLD) return 0;
        return run + 1;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            model_valid <= 1'b1;
            for (int i = 0; i < CH; i++) begin
                exp_f[i]   <= 2'd0;
                exp_run[i] <= 0;
                exp_chg[i] <= 1'b0;
            end
        end else if (model_valid) begin
            for (int i = 0; i < CH; i++) begin
                exp_f[i]   <= next_f(exp_f[i], bus.X[i], bus.Y[i], exp_run[i]);
                exp_run[i] <= next_run(exp_f[i], bus.X[i], bus.Y[i], exp_run[i]);
                exp_chg[i] <= (next_f(exp_f[i], bus.X[i], bus.Y[i], exp_run[i]) != exp_f[i]);
            end
        end
    end

    function automatic logic [CH-1:0] pack_f1();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = exp_f[i][1];
        return v;
    endfunction

    function automatic logic [CH-1:0] pack_f0();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = exp_f[i][0];
        return v;
    endfunction

    function automatic logic [CH-1:0] pack_chg();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = exp_chg[i];
        return v;
    endfunction

    function automatic logic pack_fault();
        logic v = 1'b0;
        for (int i = 0; i < CH; i++) v = v | (exp_f[i] == 2'd3);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (model_valid) begin
            check("model_F1",        32'(bus.F1),        32'(pack_f1()));
            check("model_F0",        32'(bus.F0),        32'(pack_f0()));
            check("model_changed",   32'(bus.changed),   32'(pack_chg()));
            check("model_fault_any", 32'(bus.fault_any), 32'(pack_fault()));
        end
    end

    task automatic tick(input logic [CH-1:0] x, input logic [CH-1:0] y, input logic r);
        @(negedge clock);
        bus.X = x;
        bus.Y = y;
        reset = r;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [1:0] fcode(input int k);
        return {bus.F1[k], bus.F0[k]};
    endfunction

    initial begin
        logic [CH-1:0] rx;
        logic [CH-1:0] ry;
        reset = 1'b1;
        bus.X = '1;
        bus.Y = '1;

        repeat (5) tick('1, '1, 1'b1);
        check("rst_F1",        32'(bus.F1),        0);
        check("rst_F0",        32'(bus.F0),        0);
        check("rst_changed",   32'(bus.changed),   0);
        check("rst_fault_any", 32'(bus.fault_any), 0);

        tick(4'b0001, 4'b0000, 1'b0);
        check("idle_to_run_f",   32'(fcode(0)),      32'd1);
        check("idle_to_run_chg", 32'(bus.changed),   32'b0001);
        tick(4'b0000, 4'b0000, 1'b0);
        check("run_hold_chg",    32'(bus.changed),   0);

        tick(4'b0000, 4'b0001, 1'b0);
        check("run_to_pause",    32'(fcode(0)),      32'd2);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0001, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        check("pause_2_quiet",   32'(fcode(0)),      32'd2);
        tick(4'b0000, 4'b0000, 1'b0);
        check("pause_3_quiet",   32'(fcode(0)),      32'd0);
        check("pause_exit_chg",  32'(bus.changed),   32'b0001);

        tick(4'b0100, 4'b0100, 1'b0);
        check("fault_f2",        32'(fcode(2)),      32'd3);
        check("fault_f0_idle",   32'(fcode(0)),      32'd0);
        check("fault_any_set",   32'(bus.fault_any), 32'd1);
        check("fault_chg",       32'(bus.changed),   32'b0100);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        check("fault_2_quiet",   32'(fcode(2)),      32'd3);
        tick(4'b0000, 4'b0000, 1'b0);
`ifdef XYC_STICKY_FAULT_EN
        check("fault_sticky_f",  32'(fcode(2)),      32'd3);
        check("fault_sticky_any", 32'(bus.fault_any), 32'd1);
`else
        check("fault_exit_f",    32'(fcode(2)),      32'd0);
        check("fault_exit_any",  32'(bus.fault_any), 32'd0);
`endif

        tick(4'b0000, 4'b0000, 1'b1);
        tick(4'b0010, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0010, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0010, 4'b0000, 1'b0);
        check("midhold_to_run",  32'(fcode(1)),      32'd1);
        tick(4'b0000, 4'b0010, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        check("count_cleared",   32'(fcode(1)),      32'd2);

        tick(4'b0010, 4'b0000, 1'b0);
        check("pause_to_run",    32'(fcode(1)),      32'd1);
        tick('1, '1, 1'b1);
        check("rst_run_F0",      32'(bus.F0),        0);
        check("rst_run_F1",      32'(bus.F1),        0);
        check("rst_run_chg",     32'(bus.changed),   0);

        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < CH; i++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: begin rx[i] = 1'b0; ry[i] = 1'b0; end
                    5, 6:          begin rx[i] = 1'b1; ry[i] = 1'b0; end
                    7, 8:          begin rx[i] = 1'b0; ry[i] = 1'b1; end
                    default:       begin rx[i] = 1'b1; ry[i] = 1'b1; end
                endcase
            end
            tick(rx, ry, ($urandom_range(0, 149) == 0));
        end

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
